// File: rtl/fft_config_pkg.sv
//==============================================================================
// Module  : fft_config_pkg
// Brief   : FSM state type and word-layout helpers for the FFT config generator
// Revision: 1.0
//==============================================================================
`default_nettype none

package fft_config_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Field total rounded up to a whole number of bytes.
  function automatic int cfg_tdata_w(input int num_ch, input int scale_w,
                                     input int nfft_w, input int cp_w);
    int bits;
    bits = nfft_w + cp_w + num_ch * (1 + scale_w);
    return ((bits + 7) / 8) * 8;
  endfunction

  function automatic int off_cp(input int nfft_w);
    return nfft_w;
  endfunction

  function automatic int off_fwd(input int nfft_w, input int cp_w);
    return nfft_w + cp_w;
  endfunction

  function automatic int off_scale(input int nfft_w, input int cp_w, input int num_ch);
    return nfft_w + cp_w + num_ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_config_pack.sv
//==============================================================================
// Module  : fft_config_pack
// Brief   : Combinational packer of config fields into one byte-padded word
// Revision: 1.0
//==============================================================================
`default_nettype none

module fft_config_pack
  import fft_config_pkg::*;
#(
  parameter int  NUM_CH  = 1,
  parameter int  SCALE_W = 8,
  parameter int  NFFT_W  = 0,
  parameter int  CP_W    = 0,
  localparam int TDATA_W = cfg_tdata_w(NUM_CH, SCALE_W, NFFT_W, CP_W)
) (
  input  logic [(NFFT_W > 0 ? NFFT_W : 1)-1:0]                   nfft,
  input  logic [(CP_W > 0 ? CP_W : 1)-1:0]                       cp_len,
  input  logic [NUM_CH-1:0]                                      forward,
  input  logic [(NUM_CH*SCALE_W > 0 ? NUM_CH*SCALE_W : 1)-1:0]   scale_sch,
  output logic [TDATA_W-1:0]                                     word
);

  localparam int C_OFF_CP    = off_cp(NFFT_W);
  localparam int C_OFF_FWD   = off_fwd(NFFT_W, CP_W);
  localparam int C_OFF_SCALE = off_scale(NFFT_W, CP_W, NUM_CH);

  logic [TDATA_W-1:0] w_nfft_f;
  logic [TDATA_W-1:0] w_cp_f;
  logic [TDATA_W-1:0] w_fwd_f;
  logic [TDATA_W-1:0] w_scale_f;

  // Omitted fields contribute zero; their inputs are deliberately left unused.
  if (NFFT_W > 0) begin : g_nfft
    assign w_nfft_f = TDATA_W'(nfft);
  end else begin : g_no_nfft
    logic w_unused_nfft;
    assign w_unused_nfft = ^nfft;
    assign w_nfft_f      = '0;
  end

  if (CP_W > 0) begin : g_cp
    assign w_cp_f = TDATA_W'(cp_len) << C_OFF_CP;
  end else begin : g_no_cp
    logic w_unused_cp;
    assign w_unused_cp = ^cp_len;
    assign w_cp_f      = '0;
  end

  if (SCALE_W > 0) begin : g_scale
    assign w_scale_f = TDATA_W'(scale_sch) << C_OFF_SCALE;
  end else begin : g_no_scale
    logic w_unused_scale;
    assign w_unused_scale = ^scale_sch;
    assign w_scale_f      = '0;
  end

  assign w_fwd_f = TDATA_W'(forward) << C_OFF_FWD;
  assign word    = w_nfft_f | w_cp_f | w_fwd_f | w_scale_f;

endmodule

`default_nettype wire

// File: rtl/fft_config_gen.sv
//==============================================================================
// Module  : fft_config_gen
// Brief   : AXI-Stream config-word generator with one-deep latest-wins queue
// Revision: 1.0
//==============================================================================
`default_nettype none

module fft_config_gen
  import fft_config_pkg::*;
#(
  parameter int  NUM_CH  = 1,
  parameter int  SCALE_W = 8,
  parameter int  NFFT_W  = 0,
  parameter int  CP_W    = 0,
  localparam int TDATA_W = cfg_tdata_w(NUM_CH, SCALE_W, NFFT_W, CP_W)
) (
  input  logic                                                   clk,
  input  logic                                                   resetn,
  input  logic [(NFFT_W > 0 ? NFFT_W : 1)-1:0]                   nfft,
  input  logic [(CP_W > 0 ? CP_W : 1)-1:0]                       cp_len,
  input  logic [NUM_CH-1:0]                                      forward,
  input  logic [(NUM_CH*SCALE_W > 0 ? NUM_CH*SCALE_W : 1)-1:0]   scale_sch,
  input  logic                                                   commit,
  input  logic                                                   tready,
  output logic                                                   tvalid,
  output logic                                                   tlast,
  output logic [TDATA_W-1:0]                                     tdata,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [15:0]                                            cfg_count
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TDATA_W-1:0] r_tdata;
  logic [TDATA_W-1:0] w_tdata_nxt;
  logic [TDATA_W-1:0] r_shadow;
  logic [TDATA_W-1:0] w_shadow_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_done;
  logic [15:0]        r_count;
  logic [TDATA_W-1:0] w_packed;
  logic               w_accept;

  fft_config_pack #(
    .NUM_CH  (NUM_CH),
    .SCALE_W (SCALE_W),
    .NFFT_W  (NFFT_W),
    .CP_W    (CP_W)
  ) u_pack (
    .nfft      (nfft),
    .cp_len    (cp_len),
    .forward   (forward),
    .scale_sch (scale_sch),
    .word      (w_packed)
  );

  assign w_accept = (r_state == SEND) && tready;

  always_comb begin
    w_state_nxt   = r_state;
    w_tdata_nxt   = r_tdata;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    case (r_state)
      IDLE: begin
        w_tdata_nxt   = '0;
        w_pending_nxt = 1'b0;
        if (commit) begin
          w_tdata_nxt = w_packed;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_accept) begin
          // A same-cycle commit is newer than anything queued, so it wins.
          w_pending_nxt = 1'b0;
          if (commit) begin
            w_tdata_nxt = w_packed;
          end else if (r_pending) begin
            w_tdata_nxt = r_shadow;
          end else begin
            w_tdata_nxt = '0;
            w_state_nxt = IDLE;
          end
        end else if (commit) begin
          w_shadow_nxt  = w_packed;
          w_pending_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_tdata_nxt   = '0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_tdata   <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_tdata   <= w_tdata_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_done    <= w_accept;
      if (w_accept) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign tvalid    = (r_state == SEND);
  assign tlast     = tvalid;
  assign tdata     = r_tdata;
  assign busy      = tvalid | r_pending;
  assign done      = r_done;
  assign cfg_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fft_config_gen.sv
//==============================================================================
// Module  : tb_fft_config_gen
// Brief   : Self-checking bench for fft_config_gen (configs A and B)
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fft_config_gen;
  import fft_config_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Config A: NUM_CH=1, SCALE_W=8, no NFFT, no CP -> 16-bit word
  logic [0:0]  nfft_a = '0, cp_a = '0, fwd_a = '0;
  logic [7:0]  scale_a = '0;
  logic        commit_a = 1'b0, tready_a = 1'b0;
  logic        tvalid_a, tlast_a, busy_a, done_a;
  logic [15:0] tdata_a, count_a;

  // Config B: NUM_CH=2, SCALE_W=10, NFFT_W=5 -> 32-bit word
  logic [4:0]  nfft_b = '0;
  logic [0:0]  cp_b = '0;
  logic [1:0]  fwd_b = '0;
  logic [19:0] scale_b = '0;
  logic        commit_b = 1'b0, tready_b = 1'b0;
  logic        tvalid_b, tlast_b, busy_b, done_b;
  logic [31:0] tdata_b;
  logic [15:0] count_b;

  fft_config_gen #(.NUM_CH(1), .SCALE_W(8), .NFFT_W(0), .CP_W(0)) u_dut_a (
    .clk(clk), .resetn(resetn), .nfft(nfft_a), .cp_len(cp_a), .forward(fwd_a),
    .scale_sch(scale_a), .commit(commit_a), .tready(tready_a), .tvalid(tvalid_a),
    .tlast(tlast_a), .tdata(tdata_a), .busy(busy_a), .done(done_a), .cfg_count(count_a)
  );

  fft_config_gen #(.NUM_CH(2), .SCALE_W(10), .NFFT_W(5), .CP_W(0)) u_dut_b (
    .clk(clk), .resetn(resetn), .nfft(nfft_b), .cp_len(cp_b), .forward(fwd_b),
    .scale_sch(scale_b), .commit(commit_b), .tready(tready_b), .tvalid(tvalid_b),
    .tlast(tlast_b), .tdata(tdata_b), .busy(busy_b), .done(done_b), .cfg_count(count_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model for A: words waiting to be delivered, head is on the bus.
  logic [15:0] q[$];
  bit          m_done  = 1'b0;
  int          m_count = 0;
  int          n_done  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack_a(input logic [0:0] f, input logic [7:0] s);
    return 16'(f) + 16'(s) * 16'd2;
  endfunction

  function automatic logic [31:0] pack_b(input logic [4:0] n, input logic [1:0] f,
                                         input logic [19:0] s);
    return 32'(n) + 32'(f) * 32'd32 + 32'(s[9:0]) * 32'd128 + 32'(s[19:10]) * 32'd131072;
  endfunction

  task automatic check_a();
    chk("a_tvalid", 32'(tvalid_a), 32'(q.size() > 0));
    chk("a_tlast",  32'(tlast_a),  32'(q.size() > 0));
    chk("a_tdata",  32'(tdata_a),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("a_busy",   32'(busy_a),   32'(q.size() > 0));
    chk("a_done",   32'(done_a),   32'(m_done));
    chk("a_count",  32'(count_a),  32'(m_count));
  endtask

  // One clock of A: apply the edge to the model, then compare 1 ns later.
  task automatic step();
    bit acc, locked;
    logic [15:0] v;
    @(posedge clk);
    if (resetn) begin
      acc    = (q.size() > 0) && tready_a;
      locked = (q.size() > 0) && !acc;
      m_done = acc;
      if (acc) begin
        void'(q.pop_front());
        m_count = (m_count + 1) % 65536;
        n_done++;
      end
      if (commit_a) begin
        v = pack_a(fwd_a, scale_a);
        if (q.size() > (locked ? 1 : 0)) q[q.size()-1] = v;
        else q.push_back(v);
      end
    end
    #1;
    check_a();
  endtask

  task automatic model_reset();
    q.delete();
    m_done  = 1'b0;
    m_count = 0;
  endtask

  initial begin
    logic [15:0] held;
    logic [31:0] eb;
    int guard;

    // Reset state
    resetn = 1'b0;
    repeat (3) step();
    chk("b_reset_tvalid", 32'(tvalid_b), 32'd0);
    chk("b_reset_tdata",  tdata_b, 32'd0);
    resetn = 1'b1;
    step();

    // A: basic single beat with tready high
    fwd_a = 1'b1; scale_a = 8'hA5; commit_a = 1'b1; tready_a = 1'b1;
    step();
    commit_a = 1'b0;
    chk("t1_tdata", 32'(tdata_a), 32'h014B);
    chk("t1_tvalid", 32'(tvalid_a), 32'd1);
    step();
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_count", 32'(count_a), 32'd1);
    step();

    // A: stalled by tready low for 20 cycles; inputs wiggle but must not leak
    tready_a = 1'b0; scale_a = 8'h3C; fwd_a = 1'b0; commit_a = 1'b1;
    step();
    commit_a = 1'b0;
    held = tdata_a;
    chk("t2_first", 32'(held), 32'h0078);
    for (int i = 0; i < 20; i++) begin
      scale_a = 8'($urandom); fwd_a = 1'($urandom);
      step();
      chk("t2_stable", 32'(tdata_a), 32'(held));
      chk("t2_busy", 32'(busy_a), 32'd1);
    end
    tready_a = 1'b1;
    step();
    step();
    chk("t2_idle", 32'(tvalid_a), 32'd0);

    // A: latest-wins queue while stalled
    tready_a = 1'b0; fwd_a = 1'b0;
    scale_a = 8'h11; commit_a = 1'b1; step();
    chk("t3_beat0_early", 32'(tdata_a), 32'h0022);
    scale_a = 8'h22; step();
    scale_a = 8'h33; step();
    commit_a = 1'b0; tready_a = 1'b1;
    chk("t3_beat0", 32'(tdata_a), 32'h0022);
    step();
    chk("t3_beat1", 32'(tdata_a), 32'h0066);
    chk("t3_b2b_valid", 32'(tvalid_a), 32'd1);
    step();
    chk("t3_end", 32'(tvalid_a), 32'd0);

    // B: multi-channel packing with NFFT field
    nfft_b = 5'd10; fwd_b = 2'b10; scale_b = {10'h2AB, 10'h155};
    commit_b = 1'b1; tready_b = 1'b0;
    step();
    commit_b = 1'b0;
    chk("b_tvalid", 32'(tvalid_b), 32'd1);
    chk("b_fields", 32'(tdata_b[26:0]), 32'({10'h2AB, 10'h155, 2'b10, 5'd10}));
    chk("b_pad", 32'(tdata_b[31:27]), 32'd0);
    tready_b = 1'b1;
    step(); step();
    chk("b_count", 32'(count_b), 32'd1);
    chk("b_idle", 32'(tvalid_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      nfft_b = 5'($urandom); fwd_b = 2'($urandom); scale_b = 20'($urandom);
      eb = pack_b(nfft_b, fwd_b, scale_b);
      commit_b = 1'b1; tready_b = 1'b0;
      step();
      commit_b = 1'b0;
      chk("b_rand", tdata_b, eb);
      tready_b = 1'b1;
      step(); step();
    end

    // A: reset while a beat is stalled drops tvalid immediately
    tready_a = 1'b0; commit_a = 1'b1; scale_a = 8'h5A;
    step();
    commit_a = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("rst_tvalid", 32'(tvalid_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    model_reset();
    step();
    resetn = 1'b1;
    tready_a = 1'b1; commit_a = 1'b1; scale_a = 8'h01; fwd_a = 1'b1;
    step();
    commit_a = 1'b0;
    chk("rst_resume", 32'(tdata_a), 32'h0003);
    step();
    chk("rst_resume_cnt", 32'(count_a), 32'd1);

    // A: randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      commit_a = ($urandom_range(0, 2) == 0);
      tready_a = 1'($urandom);
      scale_a  = 8'($urandom);
      fwd_a    = 1'($urandom);
      step();
    end

    // A: counter wrap after 65536 accepted beats
    commit_a = 1'b0;
    resetn = 1'b0;
    model_reset();
    step();
    resetn = 1'b1;
    n_done = 0;
    commit_a = 1'b1; tready_a = 1'b1;
    guard = 0;
    while (n_done < 65536 && guard < 70000) begin
      scale_a = 8'($urandom);
      step();
      guard++;
    end
    commit_a = 1'b0;
    chk("wrap_beats", 32'(n_done), 32'd65536);
    chk("wrap_count", 32'(count_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
